sa_feed_sequencer: RTL

Parametrised operand loader and skew sequencer for an N×N output-stationary systolic array. It accepts input-matrix and weight-matrix words over a valid/ready load port into two internal buffers. On `start` it streams them into the array's left edge (rows) and top edge (columns) with diagonal skew and zero padding, drains the array, and pulses `done`. It sits between the top-level stimulus/host interface and the PE grid, replacing the fixed 4×4 address-driven RAM loading.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_feed_buf.sv | 59 +++++
 rtl/sa_feed_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared FSM encoding, default geometry and lane-slicing helpers for the
// systolic-array feed sequencer.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sa_state_e;

    localparam int SA_N      = 4;
    localparam int SA_DATA_W = 16;
    localparam int SA_K_MAX  = 16;

    // Low bit of lane `lane` inside a packed bus of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_feed_buf.sv
// Operand buffer for one array edge: k-major storage, saturating write pointer
// and the skewed, zero-padded per-lane read for a given feed cycle.
module sa_feed_buf
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int DATA_W = SA_DATA_W,
    parameter int K_MAX  = SA_K_MAX
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           clr,
    input  logic [$clog2(K_MAX+N)-1:0]     rd_t,
    input  logic [$clog2(K_MAX+1)-1:0]     rd_k,
    output logic [$clog2(N*K_MAX+1)-1:0]   ptr,
    output logic                           full,
    output logic [N*DATA_W-1:0]            lanes
);

    localparam int DEPTH = N * K_MAX;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    assign full = (ptr == PTR_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (wr_en && !full) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

    // Contents survive reset; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[ptr[AW-1:0]] <= wr_data;
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_lane
        localparam int LO = lane_lo(l, DATA_W);
        int            k_idx;
        logic          in_win;
        logic [AW-1:0] addr;

        assign k_idx  = int'(rd_t) - l;
        assign in_win = (k_idx >= 0) && (k_idx < int'(rd_k));
        assign addr   = AW'(k_idx * N + l);
        assign lanes[LO +: DATA_W] = in_win ? mem[addr] : '0;
    end

endmodule

// File: rtl/sa_feed_sequencer.sv
// Operand loader and diagonal-skew feed sequencer for an NxN output-stationary array.
// Build option SA_FEED_WEIGHT_PERSIST_EN keeps loaded weights across runs.
//
// state | meaning
// IDLE  | accept loads, wait for a valid start
// FEED  | stream skewed operands, k_len+N-1 cycles
// DRAIN | let the array finish, N cycles
// DONE  | one-cycle completion pulse, pointers clear on exit
module sa_feed_sequencer
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int DATA_W = SA_DATA_W,
    parameter int K_MAX  = SA_K_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic                         load_sel,
    input  logic [DATA_W-1:0]            load_data,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    output logic                         busy,
    output logic                         done,
    output logic                         start_err,
    output logic                         acc_clear,
    output logic                         feed_valid,
    output logic [N*DATA_W-1:0]          a_out,
    output logic [N*DATA_W-1:0]          w_out
);

    localparam int PTR_W = $clog2(N * K_MAX + 1);
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int TW    = $clog2(K_MAX + N);
    localparam int NW    = PTR_W + KW;

    sa_state_e           state_q, state_n;
    logic [TW-1:0]       tmr_q, tmr_n;
    logic [TW-1:0]       t_q, t_n;
    logic [KW-1:0]       k_q, k_n;
    logic                start_ok, accept, err_n, ptr_clr, w_clr;
    logic [PTR_W-1:0]    pi, pw;
    logic                full_a, full_w;
    logic                wr_a, wr_w;
    logic [NW-1:0]       need;
    logic [TW-1:0]       rd_t;
    logic [KW-1:0]       rd_k;
    logic [N*DATA_W-1:0] a_lanes, w_lanes;

    assign load_ready = (state_q == IDLE) && (load_sel ? !full_w : !full_a);
    assign wr_a       = load_valid && load_ready && !load_sel;
    assign wr_w       = load_valid && load_ready && load_sel;

    // Start checks the pointers as they stand before any load on the same edge.
    assign need     = NW'(k_len) * NW'(N);
    assign start_ok = (k_len != '0) && (int'(k_len) <= K_MAX) &&
                      (NW'(pi) >= need) && (NW'(pw) >= need);

    // Read index is the feed cycle of the next cycle, since outputs are registered.
    assign rd_t = (state_q == IDLE) ? '0 : t_q + TW'(1);
    assign rd_k = (state_q == IDLE) ? k_len : k_q;

`ifdef SA_FEED_WEIGHT_PERSIST_EN
    assign w_clr = 1'b0;
`else
    assign w_clr = ptr_clr;
`endif

    sa_feed_buf #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX)) u_buf_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_a),
        .wr_data (load_data),
        .clr     (ptr_clr),
        .rd_t    (rd_t),
        .rd_k    (rd_k),
        .ptr     (pi),
        .full    (full_a),
        .lanes   (a_lanes)
    );

    sa_feed_buf #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX)) u_buf_w (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_w),
        .wr_data (load_data),
        .clr     (w_clr),
        .rd_t    (rd_t),
        .rd_k    (rd_k),
        .ptr     (pw),
        .full    (full_w),
        .lanes   (w_lanes)
    );

    always_comb begin
        state_n = state_q;
        tmr_n   = tmr_q;
        t_n     = t_q;
        k_n     = k_q;
        accept  = 1'b0;
        err_n   = 1'b0;
        ptr_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        accept  = 1'b1;
                        state_n = FEED;
                        k_n     = k_len;
                        t_n     = '0;
                        tmr_n   = TW'(int'(k_len) + N - 2);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FEED: begin
                t_n = t_q + TW'(1);
                if (tmr_q == '0) begin
                    state_n = DRAIN;
                    tmr_n   = TW'(N - 1);
                end else begin
                    tmr_n = tmr_q - TW'(1);
                end
            end
            DRAIN: begin
                if (tmr_q == '0) begin
                    state_n = DONE;
                end else begin
                    tmr_n = tmr_q - TW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                ptr_clr = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            t_q        <= '0;
            k_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
            acc_clear  <= 1'b0;
            feed_valid <= 1'b0;
            a_out      <= '0;
            w_out      <= '0;
        end else begin
            state_q    <= state_n;
            tmr_q      <= tmr_n;
            t_q        <= t_n;
            k_q        <= k_n;
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            start_err  <= err_n;
            acc_clear  <= accept;
            feed_valid <= (state_n == FEED);
            a_out      <= (state_n == FEED) ? a_lanes : '0;
            w_out      <= (state_n == FEED) ? w_lanes : '0;
        end
    end

endmodule
